// File: rtl/adder_arb_pkg.sv
// Shared definitions for the round-robin adder arbiter.
//   DATA_W  : operand / result width
//   state_t : arbiter FSM states
//   rr_next : wrap-around successor of a requester index
package adder_arb_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index following idx in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    if (idx + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/adder.sv
// 8-bit Kogge-Stone prefix adder, sum mod 256 (no carry in/out).
//   a, b : operands
//   s    : (a + b) mod 256
module adder
  import adder_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] s
);

  // Parallel-prefix carry computation; after the last level g[i] is the
  // group generate of bits [i:0], i.e. the carry into bit i+1.
  function automatic logic [DATA_W-1:0] ks_sum(input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] g_n;
    logic [DATA_W-1:0] p_n;
    g = x & y;
    p = x ^ y;
    for (int d = 1; d < DATA_W; d = d * 2) begin
      g_n = g;
      p_n = p;
      for (int i = d; i < DATA_W; i++) begin
        g_n[i] = g[i] | (p[i] & g[i-d]);
        p_n[i] = p[i] & p[i-d];
      end
      g = g_n;
      p = p_n;
    end
    return (x ^ y) ^ {g[DATA_W-2:0], 1'b0};
  endfunction

  assign s = ks_sum(a, b);

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   i_req : request vector
//   i_ptr : highest-priority index
//   o_gnt : one-hot grant (0 when nothing requested)
//   o_idx : encoded grant index
//   o_any : at least one request present
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  // Scan i_ptr, i_ptr+1, ... (mod NUM_REQ); the first hit wins.
  always_comb begin
    int c;
    c     = 0;
    o_any = 1'b0;
    o_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = (int'(i_ptr) + k) % NUM_REQ;
      if (!o_any && i_req[c[ID_W-1:0]]) begin
        o_any = 1'b1;
        o_idx = c[ID_W-1:0];
      end else begin
        o_any = o_any;
      end
    end
    o_gnt = o_any ? (NUM_REQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/adder_rr_arbiter.sv
// Shares one 8-bit adder between NUM_REQ valid/ready requesters using a
// round-robin scheduler; results return on one channel tagged by ID.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : per-requester request handshake (ready one-hot)
//   req_a, req_b        : packed operands, requester i at [8i+7:8i]
//   rsp_valid/rsp_ready : response handshake
//   rsp_data, rsp_id    : sum and owning requester
//   busy                : FSM not in IDLE
//   op_count            : completed response handshakes (wraps)
module adder_rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ID_W-1:0]           rsp_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          op_count
);

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_op_a;
  logic [DATA_W-1:0]   r_op_b;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [ID_W-1:0]     r_rsp_id;
  logic                r_rsp_valid;
  logic                r_busy;
  logic [CNT_W-1:0]    r_op_count;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_idx;
  logic                w_any;
  logic [DATA_W-1:0]   w_sum;
  logic [DATA_W-1:0]   w_a_arr [NUM_REQ];
  logic [DATA_W-1:0]   w_b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_a_arr[g] = req_a[g*DATA_W +: DATA_W];
    assign w_b_arr[g] = req_b[g*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .i_req (req_valid),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  adder u_adder (
    .a (r_op_a),
    .b (r_op_b),
    .s (w_sum)
  );

  // Grants are only offered in IDLE; rst_n gating keeps ready low during reset.
  assign req_ready = (rst_n && (r_state == IDLE)) ? w_gnt : '0;

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign busy      = r_busy;
  assign op_count  = r_op_count;

  // Arbiter FSM: grant in IDLE, compute in EXEC, hold response in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_op_a   <= w_a_arr[w_idx];
            r_op_b   <= w_b_arr[w_idx];
            r_id     <= w_idx;
            r_rr_ptr <= ID_W'(rr_next(32'(w_idx), 32'(NUM_REQ)));
            r_state  <= EXEC;
            r_busy   <= 1'b1;
          end
        end
        EXEC: begin
          r_rsp_data  <= w_sum;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_op_count  <= r_op_count + CNT_W'(1);
            r_state     <= IDLE;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: directed scenarios followed by
// random traffic, all checked against a transaction-level reference model.
module tb_adder_rr_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int CW  = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*8-1:0]  req_a;
  logic [N*8-1:0]  req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [7:0]      rsp_data;
  logic [IDW-1:0]  rsp_id;
  logic            busy;
  logic [CW-1:0]   op_count;

  adder_rr_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: priority pointer, one outstanding operation, counter.
  int m_ptr;
  int m_pend;
  int m_age;
  int m_data;
  int m_id;
  int m_cnt;
  int cyc;
  int glog[$];
  int gcyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_grant();
    int c;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (req_valid[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_pend = 0; m_age = 0; m_data = 0; m_id = 0; m_cnt = 0;
  endtask

  task automatic check_outputs();
    int g;
    logic [N-1:0] er;
    g  = (m_pend != 0) ? -1 : exp_grant();
    er = (g < 0) ? 4'b0000 : (4'b0001 << g);
    check("req_ready", 32'(req_ready), 32'(er));
    check("busy", 32'(busy), 32'(m_pend != 0));
    check("rsp_valid", 32'(rsp_valid), 32'((m_pend != 0) && (m_age >= 1)));
    if ((m_pend != 0) && (m_age >= 1)) begin
      check("rsp_data", 32'(rsp_data), 32'(m_data));
      check("rsp_id", 32'(rsp_id), 32'(m_id));
    end
    check("op_count", 32'(op_count), 32'(m_cnt));
  endtask

  // Advance the model using the inputs that were present at the edge.
  task automatic model_edge();
    int g;
    g = (m_pend != 0) ? -1 : exp_grant();
    if (g >= 0) begin
      m_pend = 1;
      m_age  = 0;
      m_id   = g;
      m_data = (int'(req_a[g*8 +: 8]) + int'(req_b[g*8 +: 8])) % 256;
      m_ptr  = (g + 1) % N;
      glog.push_back(g);
      gcyc.push_back(cyc);
    end else if (m_pend != 0) begin
      if (m_age >= 1 && rsp_ready) begin
        m_pend = 0;
        m_cnt  = (m_cnt + 1) % 65536;
      end else begin
        m_age++;
      end
    end
    cyc++;
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic rr);
    req_valid = v;
    rsp_ready = rr;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
  endtask

  initial begin
    // Power-on reset with requests already pending: nothing may be granted.
    rst_n = 1'b0; req_valid = 4'b1111; rsp_ready = 1'b0;
    req_a = '0; req_b = '0; cyc = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    req_valid = 4'b0000;
    rst_n = 1'b1;

    // Single request 0x12 + 0x34.
    set_ops(0, 8'h12, 8'h34);
    cycle(4'b0001, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Carry is discarded.
    set_ops(1, 8'hFF, 8'h01);
    cycle(4'b0010, 1'b1); cycle(4'b0000, 1'b1); cycle(4'b0000, 1'b1);
    set_ops(2, 8'h80, 8'h80);
    cycle(4'b0100, 1'b1); cycle(4'b0000, 1'b1); cycle(4'b0000, 1'b1);

    // Backpressure: response held for several cycles, no grants meanwhile.
    set_ops(3, 8'hA5, 8'h5A);
    cycle(4'b1000, 1'b0);
    repeat (6) cycle(4'b1000, 1'b0);
    cycle(4'b0000, 1'b1);
    cycle(4'b0000, 1'b1);

    // Reset while a response is pending.
    set_ops(0, 8'h01, 8'h02);
    cycle(4'b0001, 1'b0);
    cycle(4'b0000, 1'b0);
    req_valid = 4'b1111;
    #1;
    check("pre_rst_rsp_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_op_count", 32'(op_count), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    req_valid = 4'b0000;

    // All requesters held valid: order 0,1,2,3,0, one grant per 3 cycles.
    for (int i = 0; i < N; i++) set_ops(i, 8'(i), 8'h10);
    glog.delete(); gcyc.delete();
    repeat (15) cycle(4'b1111, 1'b1);
    check("rr_grant_count", 32'(glog.size()), 32'd5);
    for (int k = 0; k < 5 && k < glog.size(); k++) begin
      check("rr_grant_order", 32'(glog[k]), 32'(k % N));
      check("rr_grant_spacing", 32'(gcyc[k] - gcyc[0]), 32'(3 * k));
    end
    cycle(4'b0000, 1'b1); cycle(4'b0000, 1'b1);

    // Grant 2, a short-lived request from 1, then 0 and 3 contend: 3 wins.
    glog.delete(); gcyc.delete();
    cycle(4'b0100, 1'b1);
    cycle(4'b0010, 1'b1);
    cycle(4'b1001, 1'b1);
    repeat (3) cycle(4'b1001, 1'b1);
    cycle(4'b0001, 1'b1);
    cycle(4'b0000, 1'b1); cycle(4'b0000, 1'b1);
    check("fair_count", 32'(glog.size()), 32'd3);
    if (glog.size() == 3) begin
      check("fair_first", 32'(glog[0]), 32'd2);
      check("fair_second", 32'(glog[1]), 32'd3);
      check("fair_third", 32'(glog[2]), 32'd0);
    end

    // Random traffic with random backpressure.
    for (int t = 0; t < 400; t++) begin
      req_a = $urandom;
      req_b = $urandom;
      cycle(4'($urandom_range(0, 15)), 1'(($urandom % 4) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_rr_arbiter.md
Name: adder_rr_arbiter

Overview:
Shares one instance of the team's 8-bit prefix adder (`adder`: a, b in; s out; sum mod 256, no carry-in or carry-out) between NUM_REQ requesters.
- Each requester uses a valid/ready request channel.
- A round-robin scheduler picks one operand pair at a time and drives it through registered operands into the adder.
- The sum is returned on a single response channel, tagged with the requester ID.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
ID_W, $clog2(NUM_REQ), width of rsp_id; derived, not overridden.
CNT_W, 16, width of the completed-operation counter.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant/accept, at most one bit high
req_a  in  NUM_REQ*8  operand A; requester i uses bits [8i+7:8i]
req_b  in  NUM_REQ*8  operand B, same packing as req_a
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_data  out  8  (a+b) mod 256
rsp_id  out  ID_W  index of the requester that owns the response
busy  out  1  high in every state except IDLE
op_count  out  CNT_W  number of completed response handshakes; wraps to 0

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=IDLE, rr_ptr=0.
  - op_a, op_b, rsp_data, rsp_id, op_count all 0.
  - rsp_valid=0, busy=0, req_ready=0.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - req_ready is one-hot and combinational. It selects the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... and wrapping mod NUM_REQ.
  - req_ready is 0 when no req_valid bit is set.
  - On the handshake: op_a and op_b latch requester i's operands, id_reg=i, rr_ptr=(i+1) mod NUM_REQ, next state EXEC.
- EXEC:
  - The adder sees op_a and op_b. Its output s is registered into rsp_data, id_reg into rsp_id.
  - rsp_valid is set to 1 and the next state is RESP.
  - req_ready is 0.
- RESP:
  - rsp_valid=1. rsp_data and rsp_id hold stable until rsp_ready=1.
  - On the handshake: rsp_valid=0, op_count increments, next state IDLE.
  - req_ready is 0. There is no grant in the same cycle as the response handshake.
- Latency:
  - Request handshake at edge T gives rsp_valid=1 after edge T+1.
  - If rsp_ready is held high, the next grant is possible in the cycle after edge T+2.
  - Peak throughput is 1 operation per 3 cycles.
- Fairness:
  - A requester that holds valid is granted within NUM_REQ grants.
  - rr_ptr advances only on a grant, never on idle cycles.
- Withdrawn request: req_valid may drop before handshake; no state change and rr_ptr unchanged.
- Arithmetic: the sum is 8-bit mod 256 with the carry discarded, e.g. 0xFF+0x01 gives 0x00 and 0x80+0x80 gives 0x00.
- op_count wraps from 2^CNT_W-1 to 0.
- Reset mid-operation, in EXEC or RESP:
  - The operation is dropped and rsp_valid falls immediately.
  - op_count is not incremented.
- Simultaneous requests from all requesters are served in order rr_ptr, rr_ptr+1, ...

Decomposition:
- Package adder_arb_pkg:
  - DATA_W=8.
  - state_t enum {IDLE, EXEC, RESP}.
  - Function rr_next(idx, n).
- Sub-module rr_picker, combinational:
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, encoded index, any_valid.
- The `adder` instance sits directly in adder_rr_arbiter.

Test Plan:
- Reset mid-RESP: rst_n=0 while rsp_valid=1 -> rsp_valid, busy, op_count and rr_ptr go to 0 asynchronously, before the next clock edge.
- Single request: req_valid=0001, a0=0x12, b0=0x34, rsp_ready=1 -> req_ready=0001 for one cycle; rsp_valid=1, rsp_data=0x46, rsp_id=0 two edges later; op_count=1.
- Wrap-around: a=0xFF, b=0x01 -> rsp_data=0x00; then a=0x80, b=0x80 -> rsp_data=0x00.
- All four requesters held valid, operands a_i=i, b_i=0x10 -> grant order 0,1,2,3,0; responses 0x10,0x11,0x12,0x13 with rsp_id 0,1,2,3; one grant every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_data, rsp_id and rsp_valid stable; req_ready=0 throughout; op_count unchanged until the handshake.
- Withdrawn request and fairness: req1 valid for a cycle and then dropped, no handshake -> rr_ptr unchanged. After grant to 2, with requests 0 and 3 pending -> 3 is granted before 0.
